// File: rtl/addsub_pkg.sv
// addsub_pkg: shared constants, control bundle and saturation helpers for the pipelined add/sub unit
package addsub_pkg;
    localparam logic ADD = 1'b1;
    localparam logic SUB = 1'b0;

    typedef struct packed {
        logic v;
        logic a_s;
        logic sign;
        logic sat;
    } ctl_t;

    function automatic logic [63:0] sat_max(input int width, input logic sgn);
        return {64{1'b1}} >> (sgn ? 65 - width : 64 - width);
    endfunction

    function automatic logic [63:0] sat_min(input int width, input logic sgn);
        return sgn ? 64'd1 << (width - 1) : 64'd0;
    endfunction

    function automatic bit legal_cfg(input int width, input int stages);
        return stages >= 1 && stages <= 8 && width % stages == 0;
    endfunction
endpackage

// File: rtl/addsub_seg.sv
// addsub_seg: registered SEG-bit adder slice with carry in/out and advance enable
module addsub_seg #(
    parameter int SEG = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           en,
    input  logic [SEG-1:0] a,
    input  logic [SEG-1:0] b,
    input  logic           cin,
    output logic [SEG-1:0] s,
    output logic           cout
);
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) {cout, s} <= '0;
        else if (en) {cout, s} <= {1'b0, a} + {1'b0, b} + (SEG + 1)'(cin);
endmodule

// File: rtl/addsub_pipe.sv
// addsub_pipe: pipelined signed/unsigned add/sub with saturation, flags, sticky overflow and valid/ready
module addsub_pipe import addsub_pkg::*; #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             a_s,
    input  logic             sign,
    input  logic             sat,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             carry,
    output logic             over,
    output logic             zero,
    output logic             neg,
    output logic             sticky_over,
    input  logic             clr_sticky
);
    localparam int SEG = WIDTH / STAGES;
    localparam int L = STAGES - 1;
    localparam logic [WIDTH-1:0] UMAX = WIDTH'(sat_max(WIDTH, 1'b0));
    localparam logic [WIDTH-1:0] SMAX = WIDTH'(sat_max(WIDTH, 1'b1));
    localparam logic [WIDTH-1:0] SMIN = WIDTH'(sat_min(WIDTH, 1'b1));

    if (!legal_cfg(WIDTH, STAGES)) begin : g_bad
        $error("addsub_pipe: WIDTH must be a multiple of STAGES, STAGES in 1..8");
    end

    logic             adv;
    ctl_t             ctl_r  [STAGES];
    logic [WIDTH-1:0] a_r    [STAGES];
    logic [WIDTH-1:0] bx_r   [STAGES];
    logic [WIDTH-1:0] lo_r   [STAGES];
    logic [WIDTH-1:0] full_s [STAGES];
    logic [SEG-1:0]   s_seg  [STAGES];
    logic [STAGES-1:0] c_seg;

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    // lo_r carries the already-finished low slices; b is pre-inverted on subtract
    for (genvar k = 0; k < STAGES; k++) begin : g_st
        ctl_t             src_ctl;
        logic [WIDTH-1:0] src_a, src_bx, src_lo;
        logic             src_c;
        if (k == 0) begin : g_in
            assign src_ctl = '{v: in_valid, a_s: a_s, sign: sign, sat: sat};
            assign src_a   = a;
            assign src_bx  = (a_s == ADD) ? b : ~b;
            assign src_lo  = '0;
            assign src_c   = (a_s == SUB);
        end else begin : g_mid
            assign src_ctl = ctl_r[k-1];
            assign src_a   = a_r[k-1];
            assign src_bx  = bx_r[k-1];
            assign src_lo  = full_s[k-1];
            assign src_c   = c_seg[k-1];
        end
        addsub_seg #(.SEG(SEG)) u_seg (
            .clk  (clk),
            .rst_n(rst_n),
            .en   (adv),
            .a    (src_a[k*SEG +: SEG]),
            .b    (src_bx[k*SEG +: SEG]),
            .cin  (src_c),
            .s    (s_seg[k]),
            .cout (c_seg[k])
        );
        always_ff @(posedge clk or negedge rst_n)
            if (!rst_n) begin
                ctl_r[k] <= '0;
                a_r[k]   <= '0;
                bx_r[k]  <= '0;
                lo_r[k]  <= '0;
            end else if (adv) begin
                ctl_r[k] <= src_ctl;
                a_r[k]   <= src_a;
                bx_r[k]  <= src_bx;
                lo_r[k]  <= src_lo;
            end
        assign full_s[k] = lo_r[k] | (WIDTH'(s_seg[k]) << (k * SEG));
    end

    ctl_t             f;
    logic [WIDTH-1:0] fs, ys;
    logic             fa_msb, cu, ov;

    assign f      = ctl_r[L];
    assign fs     = full_s[L];
    assign fa_msb = a_r[L][WIDTH-1];
    assign cu     = f.a_s ? c_seg[L] : ~c_seg[L];
    assign ov     = (fa_msb == bx_r[L][WIDTH-1]) && (fs[WIDTH-1] != fa_msb);
    assign ys     = (f.sat && f.sign && ov)  ? (fa_msb ? SMIN : SMAX) :
                    (f.sat && !f.sign && cu) ? ((f.a_s == ADD) ? UMAX : '0) : fs;

    assign out_valid = f.v;
    assign y         = out_valid ? ys : '0;
    assign carry     = out_valid && !f.sign && cu;
    assign over      = out_valid && f.sign && ov;
    assign zero      = out_valid && ys == '0;
    assign neg       = out_valid && ys[WIDTH-1];

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) sticky_over <= 1'b0;
        else if (out_valid && out_ready && (carry || over)) sticky_over <= 1'b1;
        else if (clr_sticky) sticky_over <= 1'b0;
endmodule
